// File: rtl/apb_regfile_slave_pkg.sv
// Shared APB completer definitions: FSM states, response encodings and the
// counter-index helper.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } apb_state_e;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   // The last decoded word location holds the read-only transfer counter.
   function automatic int unsigned cnt_index(input int unsigned num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a requester and the register-file completer.
interface apb_regfile_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  PSELx;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSELx, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELx, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_regfile_slave_regbank.sv
// Register array with address decode, error detection and a wrapping
// transfer counter that advances on every committed transfer.
module apb_regbank
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  commit,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata_c,
   output logic                  err_c
);

   localparam int unsigned CNT_IDX = cnt_index(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];
   logic [DATA_WIDTH-1:0] xfer_cnt;

   assign err_c = (addr >= ADDR_WIDTH'(NUM_REGS)) ||
                  (write && (addr == ADDR_WIDTH'(CNT_IDX)));

   always_comb begin
      rdata_c = '0;
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
         if (addr == ADDR_WIDTH'(i)) rdata_c = regs[i];
      end
      if (addr == ADDR_WIDTH'(CNT_IDX)) rdata_c = xfer_cnt;
   end

   // Errored transfers still count; only legal writes touch the array.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
         xfer_cnt <= '0;
      end else if (commit) begin
         xfer_cnt <= xfer_cnt + DATA_WIDTH'(1);
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (write && !err_c && (addr == ADDR_WIDTH'(i))) regs[i] <= wdata;
         end
      end
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer: setup capture, programmable wait states and single-cycle
// completion in front of a register bank.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   apb_regfile_slave_if.slave apb
);

   localparam int unsigned WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   apb_state_e            state;
   logic [WCNT_W-1:0]     wcnt;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic                  cap_write;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [DATA_WIDTH-1:0] bank_rdata_c;
   logic                  bank_err_c;
   logic                  ready_c;

   // Request capture happens only on a legal setup phase seen in IDLE.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= ST_IDLE;
         wcnt      <= '0;
         cap_addr  <= '0;
         cap_write <= 1'b0;
         cap_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (apb.PSELx && !apb.PENABLE) begin
                  cap_addr  <= apb.PADDR;
                  cap_write <= apb.PWRITE;
                  cap_wdata <= apb.PWDATA;
                  if (WAIT_STATES == 0) begin
                     state <= ST_READY;
                  end else begin
                     state <= ST_WAIT;
                     wcnt  <= WCNT_W'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (!apb.PSELx)          state <= ST_IDLE;
               else if (wcnt == '0)     state <= ST_READY;
               else                     wcnt  <= wcnt - WCNT_W'(1);
            end
            ST_READY: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign ready_c = (state == ST_READY);

   apb_regbank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regbank (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .commit  (ready_c),
      .addr    (cap_addr),
      .write   (cap_write),
      .wdata   (cap_wdata),
      .rdata_c (bank_rdata_c),
      .err_c   (bank_err_c)
   );

   assign apb.PREADY  = ready_c;
   assign apb.PSLVERR = (ready_c && bank_err_c) ? RESP_ERROR : RESP_OKAY;
   assign apb.PRDATA  = (ready_c && !cap_write && !bank_err_c) ? bank_rdata_c : '0;

endmodule
